// File: rtl/alu_pkg.sv
// Shared types for the ALU arbiter slice: op codes, flag layout, arbiter state.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

  parameter int ALU_W = 32;

  // Encoding is owned by the alu; the arbiter only carries it through.
  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    AND = 2'b10,
    ORR = 2'b11
  } alu_op_t;

  // Bit order matches the alu ALUFlags bus: {N,Z,C,V}.
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } arb_state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of request, response, alu-side and stall-counter signals of alu_arbiter.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on req0/req1 and rsp0/rsp1; alu side is unthrottled.
// Ports: req{0,1}_{valid,ready,op,a,b}, rsp{0,1}_{valid,ready,result,flags},
//        alu_{a,b,ctrl,result,flags}, stall_cnt{0,1}.
// slave = arbiter side, master = issue logic / alu / bench side.
interface alu_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             req0_valid, req0_ready;
  logic [1:0]       req0_op;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic             req1_valid, req1_ready;
  logic [1:0]       req1_op;
  logic [WIDTH-1:0] req1_a, req1_b;

  logic             rsp0_valid, rsp0_ready;
  logic [WIDTH-1:0] rsp0_result;
  logic [3:0]       rsp0_flags;
  logic             rsp1_valid, rsp1_ready;
  logic [WIDTH-1:0] rsp1_result;
  logic [3:0]       rsp1_flags;

  logic [WIDTH-1:0] alu_a, alu_b;
  logic [1:0]       alu_ctrl;
  logic [WIDTH-1:0] alu_result;
  logic [3:0]       alu_flags;

  logic [CNT_W-1:0] stall_cnt0, stall_cnt1;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_result, rsp0_flags,
    output rsp1_valid, rsp1_result, rsp1_flags,
    input  rsp0_ready, rsp1_ready,
    output alu_a, alu_b, alu_ctrl,
    input  alu_result, alu_flags,
    output stall_cnt0, stall_cnt1
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_result, rsp0_flags,
    input  rsp1_valid, rsp1_result, rsp1_flags,
    output rsp0_ready, rsp1_ready,
    input  alu_a, alu_b, alu_ctrl,
    output alu_result, alu_flags,
    input  stall_cnt0, stall_cnt1
  );
endinterface

// File: rtl/alu_rr_pick.sv
// Two-way round-robin picker: chooses among eligible requesters, favouring the one not granted last.
// Latency: combinational.
// Backpressure: none; grant_valid low when nobody is eligible.
// Ports: elig[1:0] eligible mask, last_grant id of previous winner,
//        grant_valid someone wins, grant_id winning requester.
module alu_rr_pick (
  input  logic [1:0] elig,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_id
);

  always_comb begin
    grant_valid = |elig;
    grant_id    = 1'b0;
    case (elig)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~last_grant;
      default: grant_id = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational alu between two requesters, round-robin, with per-requester response registers.
// Latency: accept at edge k, response valid after edge k+1; one op per two cycles.
// Backpressure: a requester with an undrained response is never granted; ready only in IDLE.
// Ports: clk, reset (async, active-high), bus (alu_arbiter_if.slave).
// Optional: define ALU_ARB_STALL_CNT_EN for saturating per-requester stall counters;
//           otherwise stall_cnt0/1 read as zero and no counter flops exist.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         reset,
  alu_arbiter_if.slave bus
);

  arb_state_t       r_state;
  alu_op_t          r_op;
  logic [WIDTH-1:0] r_a, r_b;
  logic             r_owner;
  logic             r_last_grant;
  logic [1:0]       r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_result0, r_rsp_result1;
  alu_flags_t       r_rsp_flags0, r_rsp_flags1;

  logic [1:0]       w_elig;
  logic             w_grant_valid, w_grant_id;
  logic             w_rdy0, w_rdy1;

  // Uses the registered response valid, so a drain in this cycle only
  // re-enables the requester from the next cycle on.
  assign w_elig = {bus.req1_valid & ~r_rsp_valid[1], bus.req0_valid & ~r_rsp_valid[0]};

  alu_rr_pick u_pick (
    .elig        (w_elig),
    .last_grant  (r_last_grant),
    .grant_valid (w_grant_valid),
    .grant_id    (w_grant_id)
  );

  assign w_rdy0 = (r_state == IDLE) && w_grant_valid && !w_grant_id;
  assign w_rdy1 = (r_state == IDLE) && w_grant_valid &&  w_grant_id;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_op          <= ADD;
      r_a           <= '0;
      r_b           <= '0;
      r_owner       <= 1'b0;
      r_last_grant  <= 1'b1;
      r_rsp_valid   <= 2'b00;
      r_rsp_result0 <= '0;
      r_rsp_result1 <= '0;
      r_rsp_flags0  <= '0;
      r_rsp_flags1  <= '0;
    end else begin
      if (r_rsp_valid[0] && bus.rsp0_ready) r_rsp_valid[0] <= 1'b0;
      if (r_rsp_valid[1] && bus.rsp1_ready) r_rsp_valid[1] <= 1'b0;
      case (r_state)
        IDLE: begin
          // A grant implies the winner is valid, so grant == accept here.
          if (w_grant_valid) begin
            r_owner      <= w_grant_id;
            r_last_grant <= w_grant_id;
            r_op         <= alu_op_t'(w_grant_id ? bus.req1_op : bus.req0_op);
            r_a          <= w_grant_id ? bus.req1_a : bus.req0_a;
            r_b          <= w_grant_id ? bus.req1_b : bus.req0_b;
            r_state      <= EXEC;
          end
        end
        EXEC: begin
          // Owner's response was empty at grant and cannot fill meanwhile,
          // so this never collides with the drain above.
          if (r_owner) begin
            r_rsp_valid[1] <= 1'b1;
            r_rsp_result1  <= bus.alu_result;
            r_rsp_flags1   <= alu_flags_t'(bus.alu_flags);
          end else begin
            r_rsp_valid[0] <= 1'b1;
            r_rsp_result0  <= bus.alu_result;
            r_rsp_flags0   <= alu_flags_t'(bus.alu_flags);
          end
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.req0_ready  = w_rdy0;
  assign bus.req1_ready  = w_rdy1;
  assign bus.rsp0_valid  = r_rsp_valid[0];
  assign bus.rsp1_valid  = r_rsp_valid[1];
  assign bus.rsp0_result = r_rsp_result0;
  assign bus.rsp1_result = r_rsp_result1;
  assign bus.rsp0_flags  = r_rsp_flags0;
  assign bus.rsp1_flags  = r_rsp_flags1;
  // Driven from the latched operands in both states so the alu inputs stay quiet.
  assign bus.alu_a       = r_a;
  assign bus.alu_b       = r_b;
  assign bus.alu_ctrl    = r_op;

`ifdef ALU_ARB_STALL_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt0, r_stall_cnt1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt0 <= '0;
      r_stall_cnt1 <= '0;
    end else begin
      if (bus.req0_valid && !w_rdy0 && !(&r_stall_cnt0)) r_stall_cnt0 <= r_stall_cnt0 + 1'b1;
      if (bus.req1_valid && !w_rdy1 && !(&r_stall_cnt1)) r_stall_cnt1 <= r_stall_cnt1 + 1'b1;
    end
  end

  assign bus.stall_cnt0 = r_stall_cnt0;
  assign bus.stall_cnt1 = r_stall_cnt1;
`else
  assign bus.stall_cnt0 = {CNT_W{1'b0}};
  assign bus.stall_cnt1 = {CNT_W{1'b0}};
`endif

endmodule
